// File: rtl/mem_bist.sv
// mem_bist: memory built-in self-test engine.
// Writes a programmable range of words with a selectable pattern, then reads the
// range back and compares it. Reports pass/fail, a saturating mismatch count,
// the first mismatch, and a read-timeout flag. One command at most every two
// cycles and a single outstanding read.
module mem_bist #(
  parameter int          ADDR_W        = 26,
  parameter int          DATA_W        = 32,
  parameter int          ADDR_STEP     = 4,
  parameter logic [1:0]  WIDTH_CODE    = 2'b11,
  parameter logic [31:0] FIXED_PATTERN = 32'h0123ABCD,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001,
  parameter int          TIMEOUT       = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              passed,
  output logic              failed,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  input  logic              mem_rd_ready,
  input  logic              mem_wr_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [1:0]        mem_data_width,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_GAP   = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_GAP   = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [31:0]       LFSR_POLY = 32'h8020_0003;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] WALK_INIT = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam int                AW_MIN    = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  // One step of the 32-bit right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ ({32{v[0]}} & LFSR_POLY);
  endfunction

  state_t            state_r, state_nx_s;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] base_r;
  logic [15:0]       count_r;
  logic [16:0]       idx_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [31:0]       lfsr_r;
  logic [DATA_W-1:0] walk_r;
  logic              hold_valid_r;
  logic [DATA_W-1:0] hold_data_r;
  logic [31:0]       tcnt_r;

  logic              accept_s, wr_fire_s, rd_fire_s, wr_last_s, rd_last_s;
  logic              rd_avail_s, cmp_s, rd_to_s, mismatch_s;
  logic [DATA_W-1:0] pat_s, rd_word_s;
  logic [15:0]       err_next_s;

  assign mem_data_width = WIDTH_CODE;

  // Pattern for the current word index.
  always_comb begin
    pat_s = {DATA_W{1'b0}};
    case (mode_r)
      2'd0: pat_s = FIXED_PATTERN[DATA_W-1:0];
      2'd1: pat_s[AW_MIN-1:0] = cur_addr_r[AW_MIN-1:0];
      2'd2: pat_s = walk_r;
      2'd3: pat_s = lfsr_r[DATA_W-1:0];
      default: pat_s = {DATA_W{1'b0}};
    endcase
  end

  // Per-cycle strobes: command issue, compare, timeout and mismatch bookkeeping.
  always_comb begin
    accept_s   = ((state_r == S_IDLE) || (state_r == S_DONE)) && start;
    wr_fire_s  = (state_r == S_WR_ISSUE) && mem_wr_ready;
    rd_fire_s  = (state_r == S_RD_ISSUE) && mem_rd_ready;
    wr_last_s  = (idx_r == {1'b0, count_r});
    rd_last_s  = ((idx_r + 17'd1) == {1'b0, count_r});
    rd_avail_s = hold_valid_r || mem_rd_valid;
    // data captured during RD_GAP takes precedence over the live bus
    rd_word_s  = hold_valid_r ? hold_data_r : mem_rd_data;
    cmp_s      = (state_r == S_RD_WAIT) && rd_avail_s;
    rd_to_s    = (state_r == S_RD_WAIT) && !rd_avail_s && (tcnt_r == TO_LAST);
    mismatch_s = cmp_s && (rd_word_s != pat_s);
    if (mismatch_s && (err_count != 16'hFFFF)) begin
      err_next_s = err_count + 16'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx_s = (word_count == 16'd0) ? S_DONE : S_WR_ISSUE;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_WR_ISSUE: state_nx_s = mem_wr_ready ? S_WR_GAP : S_WR_ISSUE;
      S_WR_GAP:   state_nx_s = wr_last_s ? S_RD_ISSUE : S_WR_ISSUE;
      S_RD_ISSUE: state_nx_s = mem_rd_ready ? S_RD_GAP : S_RD_ISSUE;
      S_RD_GAP:   state_nx_s = S_RD_WAIT;
      S_RD_WAIT: begin
        if (cmp_s) begin
          state_nx_s = rd_last_s ? S_DONE : S_RD_ISSUE;
        end else if (rd_to_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_RD_WAIT;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered outputs, word walker and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      passed         <= 1'b0;
      failed         <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= {ADDR_W{1'b0}};
      first_err_exp  <= {DATA_W{1'b0}};
      first_err_got  <= {DATA_W{1'b0}};
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= {ADDR_W{1'b0}};
      mem_wr_data    <= {DATA_W{1'b0}};
      mode_r         <= 2'd0;
      base_r         <= {ADDR_W{1'b0}};
      count_r        <= 16'd0;
      idx_r          <= 17'd0;
      cur_addr_r     <= {ADDR_W{1'b0}};
      lfsr_r         <= LFSR_SEED;
      walk_r         <= WALK_INIT;
      hold_valid_r   <= 1'b0;
      hold_data_r    <= {DATA_W{1'b0}};
      tcnt_r         <= 32'd0;
    end else begin
      mem_wr <= wr_fire_s;
      mem_rd <= rd_fire_s;
      busy   <= (state_nx_s != S_IDLE) && (state_nx_s != S_DONE);
      done   <= (state_nx_s == S_DONE);
      if (accept_s) begin
        mode_r         <= mode;
        base_r         <= base_addr;
        count_r        <= word_count;
        idx_r          <= 17'd0;
        cur_addr_r     <= base_addr;
        lfsr_r         <= LFSR_SEED;
        walk_r         <= WALK_INIT;
        err_count      <= 16'd0;
        first_err_addr <= {ADDR_W{1'b0}};
        first_err_exp  <= {DATA_W{1'b0}};
        first_err_got  <= {DATA_W{1'b0}};
        timeout        <= 1'b0;
        hold_valid_r   <= 1'b0;
        // an empty range passes immediately without touching memory
        passed         <= (word_count == 16'd0);
        failed         <= 1'b0;
      end else begin
        case (state_r)
          S_WR_ISSUE: begin
            if (wr_fire_s) begin
              mem_addr    <= cur_addr_r;
              mem_wr_data <= pat_s;
              idx_r       <= idx_r + 17'd1;
              cur_addr_r  <= cur_addr_r + STEP;
              lfsr_r      <= lfsr_step(lfsr_r);
              walk_r      <= {walk_r[DATA_W-2:0], walk_r[DATA_W-1]};
            end
          end
          S_WR_GAP: begin
            // rewind the walker so the read pass regenerates the same sequence
            if (wr_last_s) begin
              idx_r      <= 17'd0;
              cur_addr_r <= base_r;
              lfsr_r     <= LFSR_SEED;
              walk_r     <= WALK_INIT;
            end
          end
          S_RD_ISSUE: begin
            if (rd_fire_s) begin
              mem_addr     <= cur_addr_r;
              tcnt_r       <= 32'd0;
              hold_valid_r <= 1'b0;
            end
          end
          S_RD_GAP: begin
            tcnt_r <= tcnt_r + 32'd1;
            if (mem_rd_valid) begin
              hold_valid_r <= 1'b1;
              hold_data_r  <= mem_rd_data;
            end
          end
          S_RD_WAIT: begin
            if (cmp_s) begin
              hold_valid_r <= 1'b0;
              err_count    <= err_next_s;
              if (mismatch_s && (err_count == 16'd0)) begin
                first_err_addr <= cur_addr_r;
                first_err_exp  <= pat_s;
                first_err_got  <= rd_word_s;
              end
              idx_r      <= idx_r + 17'd1;
              cur_addr_r <= cur_addr_r + STEP;
              lfsr_r     <= lfsr_step(lfsr_r);
              walk_r     <= {walk_r[DATA_W-2:0], walk_r[DATA_W-1]};
              if (rd_last_s) begin
                passed <= (err_next_s == 16'd0) && !timeout;
                failed <= !((err_next_s == 16'd0) && !timeout);
              end
            end else if (rd_to_s) begin
              timeout <= 1'b1;
              passed  <= 1'b0;
              failed  <= 1'b1;
            end else begin
              tcnt_r <= tcnt_r + 32'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Directed testbench for mem_bist with a small behavioural memory model.
module tb_mem_bist;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode;
  logic [25:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, passed, failed, timeout;
  logic [15:0] err_count;
  logic [25:0] first_err_addr;
  logic [31:0] first_err_exp, first_err_got;
  logic        mem_rd_ready, mem_wr_ready;
  logic        mem_rd, mem_wr;
  logic [25:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_rd_data  = 32'h0;
  logic        mem_rd_valid = 1'b0;

  always #5 clk = ~clk;

  mem_bist #(
    .ADDR_W(26), .DATA_W(32), .ADDR_STEP(4), .WIDTH_CODE(2'b11),
    .FIXED_PATTERN(32'h0123ABCD), .LFSR_SEED(32'hACE1_0001), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .passed(passed),
    .failed(failed), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .mem_rd_ready(mem_rd_ready),
    .mem_wr_ready(mem_wr_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_data_width(mem_data_width), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid)
  );

  // Memory model state and command logs
  logic [25:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [25:0] rd_addr_q[$];
  int          wr_b2b    = 0;
  logic        wr_prev   = 1'b0;
  int          lat_cfg   = 3;
  bit          no_resp   = 1'b0;
  bit          flip_en   = 1'b0;
  logic [25:0] flip_addr = 26'h0;
  int          pend_cnt  = 0;
  logic [25:0] pend_addr = 26'h0;

  int checks = 0;
  int errors = 0;

  // Latest data written to an address, with optional bit-0 corruption.
  function automatic logic [31:0] lookup(input logic [25:0] a);
    logic [31:0] d;
    d = 32'hDEAD_BEEF;
    for (int k = wr_addr_q.size() - 1; k >= 0; k--) begin
      if (wr_addr_q[k] == a) begin
        d = wr_data_q[k];
        break;
      end
    end
    if (flip_en && (a == flip_addr)) d = d ^ 32'h1;
    return d;
  endfunction

  // Memory model: logs commands mid-cycle and returns read data after lat_cfg cycles.
  always @(negedge clk) begin
    mem_rd_valid <= 1'b0;
    if (mem_wr === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wr_data);
      if (wr_prev === 1'b1) wr_b2b <= wr_b2b + 1;
    end
    wr_prev <= mem_wr;
    if (mem_rd === 1'b1) begin
      rd_addr_q.push_back(mem_addr);
      if (!no_resp) begin
        if (lat_cfg == 0) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= lookup(mem_addr);
        end else begin
          pend_cnt  <= lat_cfg;
          pend_addr <= mem_addr;
        end
      end
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= lookup(pend_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [25:0] b, input logic [15:0] c);
    @(negedge clk);
    mode = m; base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_wr);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      if (rand_wr) mem_wr_ready = 1'($urandom_range(0, 1));
      n++;
    end
    mem_wr_ready = 1'b1;
    chk("done_within_budget", done, 1);
  endtask

  task automatic wait_rd(input int budget);
    int n;
    n = 0;
    while (mem_rd !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("mem_rd_seen", mem_rd, 1);
  endtask

  int          wb, rb, b2b0, n;
  logic [25:0] exp_a [4];
  logic [31:0] one;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; base_addr = 26'h0; word_count = 16'd0;
    mem_rd_ready = 1'b1; mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_passed", passed, 0);
    chk("rst_failed", failed, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_count, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_width", mem_data_width, 2'b11);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, single word, 3-cycle read latency
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); lat_cfg = 3;
    do_start(2'd0, 26'h0, 16'd1);
    chk("t1_busy", busy, 1);
    wait_done(100, 1'b0);
    chk("t1_nwr", wr_addr_q.size() - wb, 1);
    chk("t1_wr_addr", wr_addr_q[wb], 26'h0);
    chk("t1_wr_data", wr_data_q[wb], 32'h0123ABCD);
    chk("t1_nrd", rd_addr_q.size() - rb, 1);
    chk("t1_rd_addr", rd_addr_q[rb], 26'h0);
    chk("t1_passed", passed, 1);
    chk("t1_failed", failed, 0);
    chk("t1_err", err_count, 0);
    chk("t1_busy_end", busy, 0);

    // Mode 1, address range wrapping past the top of memory
    exp_a[0] = 26'h3FFFFF8; exp_a[1] = 26'h3FFFFFC; exp_a[2] = 26'h0000000; exp_a[3] = 26'h0000004;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    do_start(2'd1, 26'h3FFFFF8, 16'd4);
    chk("t2_done_cleared", done, 0);
    wait_done(200, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr_addr", wr_addr_q[wb + i], exp_a[i]);
      chk("t2_wr_data", wr_data_q[wb + i], {6'd0, exp_a[i]});
      chk("t2_rd_addr", rd_addr_q[rb + i], exp_a[i]);
    end
    chk("t2_passed", passed, 1);
    chk("t2_err", err_count, 0);

    // Zero read latency: data arrives in the gap cycle and must be held
    rb = rd_addr_q.size(); lat_cfg = 0;
    do_start(2'd0, 26'h100, 16'd3);
    wait_done(200, 1'b0);
    chk("t2b_nrd", rd_addr_q.size() - rb, 3);
    chk("t2b_passed", passed, 1);
    chk("t2b_err", err_count, 0);
    lat_cfg = 3;

    // Mode 3 LFSR, 256 words, bit 0 corrupted at word 5
    wb = wr_addr_q.size(); flip_en = 1'b1; flip_addr = 26'h1014;
    do_start(2'd3, 26'h1000, 16'd256);
    wait_done(4000, 1'b0);
    flip_en = 1'b0;
    chk("t3_nwr", wr_addr_q.size() - wb, 256);
    chk("t3_lfsr_w0", wr_data_q[wb], 32'hACE1_0001);
    chk("t3_lfsr_w1", wr_data_q[wb + 1], 32'hD650_8003);
    chk("t3_err", err_count, 1);
    chk("t3_err_addr", first_err_addr, 26'h1014);
    chk("t3_err_exp", first_err_exp, wr_data_q[wb + 5]);
    chk("t3_err_got", first_err_got, wr_data_q[wb + 5] ^ 32'h1);
    chk("t3_failed", failed, 1);
    chk("t3_passed", passed, 0);
    chk("t3_timeout", timeout, 0);

    // Memory never answers: timeout after 16 cycles
    no_resp = 1'b1;
    do_start(2'd0, 26'h0, 16'd2);
    wait_rd(100);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_latency", (n >= 16) && (n <= 20), 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_failed", failed, 1);
    chk("t4_passed", passed, 0);
    no_resp = 1'b0;

    // Mode 2 with random write backpressure
    wb = wr_addr_q.size(); b2b0 = wr_b2b; one = 32'h1;
    do_start(2'd2, 26'h2000, 16'd40);
    wait_done(2000, 1'b1);
    chk("t5_no_b2b", wr_b2b - b2b0, 0);
    chk("t5_nwr", wr_addr_q.size() - wb, 40);
    for (int i = 0; i < 40; i++) begin
      chk("t5_wr_data", wr_data_q[wb + i], one << (i % 32));
    end
    chk("t5_passed", passed, 1);

    // Reset in the cycle a second read would be issued
    do_start(2'd0, 26'h400, 16'd8);
    wait_rd(200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mem_rd", mem_rd, 0);
    chk("t6_mem_wr", mem_wr, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Empty range after reset
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    do_start(2'd0, 26'h0, 16'd0);
    chk("t7_done", done, 1);
    chk("t7_passed", passed, 1);
    chk("t7_failed", failed, 0);
    chk("t7_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("t7_nwr", wr_addr_q.size() - wb, 0);
    chk("t7_nrd", rd_addr_q.size() - rb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Parametrised memory built-in self-test engine that sits on the mux-to-memory port in place of the mux's hard-coded single-word write/read check. On `start` it writes a programmable range of words with a selectable data pattern, then reads the range back and compares every word. It reports pass/fail, a saturating error count, details of the first mismatch and a read-timeout flag. It is used for bring-up of the external memory before cart/USB traffic is enabled.

## Interface
Parameters:
- `ADDR_W`, 26, memory address width.
- `DATA_W`, 32, data width; legal values are 16 and 32.
- `ADDR_STEP`, 4, address increment per word.
- `WIDTH_CODE`, 2'b11, constant driven on `mem_data_width` (01: 8-bit, 10: 16-bit, 11: 32-bit).
- `FIXED_PATTERN`, 32'h0123ABCD, data for mode 0, truncated to `DATA_W`.
- `LFSR_SEED`, 32'hACE1_0001, seed for mode 3; must be nonzero.
- `TIMEOUT`, 1024, maximum cycles to wait for `mem_rd_valid`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `mode`  in  2  pattern: 0 fixed, 1 address-as-data, 2 walking one, 3 LFSR. Sampled with `start`.
- `base_addr`  in  ADDR_W  first word address. Sampled with `start`.
- `word_count`  in  16  number of words to test. Sampled with `start`.
- `busy`  out  1  test in progress.
- `done`  out  1  sticky; cleared by the next accepted `start`.
- `passed`, `failed`  out  1 each  valid while `done`; exactly one is high.
- `timeout`  out  1  the test ended on a read timeout.
- `err_count`  out  16  number of mismatches, saturating at 16'hFFFF.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_exp`, `first_err_got`  out  DATA_W each  expected and read data at the first mismatch.
- `mem_rd_ready`, `mem_wr_ready`  in  1 each  memory can accept a command.
- `mem_rd`, `mem_wr`  out  1 each  one-cycle command pulses.
- `mem_addr`  out  ADDR_W  command address.
- `mem_wr_data`  out  DATA_W  write data.
- `mem_data_width`  out  2  `WIDTH_CODE`.
- `mem_rd_data`  in  DATA_W  read data.
- `mem_rd_valid`  in  1  read data strobe.

## Operation
- States: IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_GAP, RD_WAIT, DONE.
- IDLE or DONE + `start`:
  - latch `mode`, `base_addr` and `word_count`.
  - clear `err_count`, all first-error fields, `timeout` and `done`.
  - set index = 0 and reload the LFSR with `LFSR_SEED`.
  - go to WR_ISSUE; if `word_count` is 0, go to DONE with `passed` = 1 and issue no traffic.
- WR_ISSUE:
  - when `mem_wr_ready` is high, register `mem_wr` = 1, `mem_addr` = addr(i) and `mem_wr_data` = pat(i); advance i.
  - go to WR_GAP.
  - WR_GAP drops `mem_wr`. After the last word, reset i and the LFSR and go to RD_ISSUE; otherwise go back to WR_ISSUE.
- RD_ISSUE:
  - when `mem_rd_ready` is high, register `mem_rd` = 1 and `mem_addr` = addr(i).
  - go to RD_GAP, which drops `mem_rd`, then RD_WAIT.
- RD_WAIT:
  - on `mem_rd_valid`, compare `mem_rd_data` with pat(i).
  - on mismatch, increment `err_count` (saturating); if this is the first error, capture addr, expected and got.
  - advance i; go to DONE after the last word, otherwise back to RD_ISSUE.
- `mem_rd_valid` outside RD_WAIT is ignored.
- Address: addr(i) = `base_addr` + i*`ADDR_STEP`, modulo 2^ADDR_W, so the range may wrap.
- Patterns, truncated to `DATA_W`:
  - mode 0: `FIXED_PATTERN`.
  - mode 1: addr(i), zero-extended or truncated.
  - mode 2: 1 << (i mod `DATA_W`).
  - mode 3: 32-bit Galois LFSR, polynomial 32'h80200003. It advances once per word and is regenerated from the seed for the read pass.
- DONE: `passed` = (`err_count` == 0) & ~`timeout`; `failed` is its complement.

## Timing
- Reset values: every output is 0 (except `mem_data_width` = `WIDTH_CODE`) and the state is IDLE. Reset during a test aborts it, and `mem_rd`/`mem_wr` are low on the next edge.
- `start` is sampled at edge t; `busy` = 1 from t+1 until DONE is entered.
- Commands are registered: a `*_ready` high sampled at edge t puts a pulse on the port during cycle t+1. At most one command is issued every 2 cycles, so a full write pass with ready held high takes 2·N cycles.
- At most one read is outstanding. `mem_rd_valid` may arrive in the RD_GAP cycle or later; if it arrives during RD_GAP it is held and compared on entry to RD_WAIT.
- Read timeout: a counter starts at the `mem_rd` pulse. If no valid arrives within `TIMEOUT` cycles, `timeout` = 1, `failed` = 1 and the block goes to DONE.
- `done`, `passed` and `failed` are asserted on the cycle after the final compare.

## Test plan
- Mode 0, base 0, count 1, memory model with 3-cycle read latency:
  - expect one write of 32'h0123ABCD to addr 0, then one read.
  - expect `passed` = 1 and `err_count` = 0.
- Mode 1, base 26'h3FFFFF8, count 4, `ADDR_STEP` 4:
  - expect addresses 3FFFFF8, 3FFFFFC, 0000000, 0000004, with data equal to each address.
  - expect `passed` = 1.
- Mode 3, count 256, model flips bit 0 at word 5 (addr base+20):
  - expect `err_count` = 1 and `first_err_addr` = base+20.
  - expect `first_err_got` = `first_err_exp` ^ 1 and `failed` = 1.
- Model never returns `mem_rd_valid`, `TIMEOUT` = 16: expect `timeout` = 1 and `failed` = 1 within 20 cycles of the first `mem_rd`.
- `mem_wr_ready` toggled randomly, mode 2, count 40:
  - `mem_wr` is never high on consecutive cycles.
  - writes carry 1<<(i mod 32).
  - expect `passed` = 1.
- Backpressure and reset:
  - assert `rst` mid read pass: next cycle `busy` = 0 and `mem_rd` = 0.
  - a new `start` with count 0 gives `done` = 1 and `passed` = 1 with no commands.
